// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the fetch stage and its neighbours.
// Holds the instruction-memory geometry, special instruction encodings,
// opcode field values, and the fetch halt-state encoding.
package pipe_pkg;

  localparam int unsigned MEM_DEPTH = 2048;
  localparam int unsigned PC_W      = $clog2(MEM_DEPTH);

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  typedef enum logic {
    FS_RUN  = 1'b0,
    FS_HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/if_fetch_stage_pc_counter.sv
// Program counter register with load / hold / increment-with-wrap.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset (pc -> 0)
//   load         : take load_val on the next edge (highest priority)
//   load_val     : redirect address
//   inc          : advance pc by one, wrapping at MEM_DEPTH
//   pc           : current PC register
//   pc_inc       : pc + 1 modulo MEM_DEPTH (combinational)
module pc_counter
  #(
    parameter int unsigned MEM_DEPTH = 2048,
    parameter int unsigned PC_W      = $clog2(MEM_DEPTH)
  )
  (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            load,
    input  logic [PC_W-1:0] load_val,
    input  logic            inc,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_inc
  );

  // Explicit wrap so a non-power-of-two depth still returns to zero.
  always_comb begin
    pc_inc = '0;
    if (pc != PC_W'(MEM_DEPTH - 1))
      pc_inc = pc + PC_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      pc <= '0;
    else if (load)
      pc <= load_val;
    else if (inc)
      pc <= pc_inc;
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory
// address, captures the returned word into the IF/ID register, and handles
// stalls, branch redirects (with wrong-path squash) and the HALT word.
// Ports:
//   clk, reset_n    : clock, asynchronous active-low reset
//   stall           : hold PC, IF/ID, halt state and fetch counter
//   branch_taken    : redirect to branch_target, squash IF/ID, leave HALT
//   branch_target   : redirect word address (low PC_W bits used)
//   imem_addr       : zero-extended PC to instruction memory
//   imem_data       : instruction word from memory (combinational)
//   pc              : current PC register
//   ifid_instr      : IF/ID instruction
//   ifid_pc_plus1   : IF/ID PC+1 (wrapped, zero-extended)
//   ifid_valid      : IF/ID holds a real instruction
//   halted          : HALT fetched, fetch frozen
//   fetch_count     : accepted fetches, saturating
module if_fetch_stage
  import pipe_pkg::*;
  #(
    parameter  int unsigned MEM_DEPTH = pipe_pkg::MEM_DEPTH,
    parameter  logic [31:0] HALT_WORD = pipe_pkg::HALT_WORD,
    parameter  logic [31:0] NOP_WORD  = pipe_pkg::NOP_WORD,
    localparam int unsigned PC_W      = $clog2(MEM_DEPTH)
  )
  (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [31:0]     branch_target,
    output logic [31:0]     imem_addr,
    input  logic [31:0]     imem_data,
    output logic [PC_W-1:0] pc,
    output logic [31:0]     ifid_instr,
    output logic [31:0]     ifid_pc_plus1,
    output logic            ifid_valid,
    output logic            halted,
    output logic [31:0]     fetch_count
  );

  fetch_state_t    state;
  fetch_state_t    state_nxt;
  logic [PC_W-1:0] pc_inc;
  logic            is_halt_word;
  logic            pc_load;
  logic            pc_advance;
  logic            accept;
  logic            unused_target_hi;

  assign unused_target_hi = ^branch_target[31:PC_W];

  assign imem_addr    = {{(32-PC_W){1'b0}}, pc};
  assign is_halt_word = (imem_data == HALT_WORD);

  // A fetch is accepted when no redirect, no stall and not already halted.
  assign accept     = !branch_taken && !stall && (state == FS_RUN);
  assign pc_load    = branch_taken;
  assign pc_advance = accept && !is_halt_word;

  pc_counter #(
    .MEM_DEPTH (MEM_DEPTH),
    .PC_W      (PC_W)
  ) u_pc_counter (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (pc_load),
    .load_val (branch_target[PC_W-1:0]),
    .inc      (pc_advance),
    .pc       (pc),
    .pc_inc   (pc_inc)
  );

  // Halt FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= FS_RUN;
    else
      state <= state_nxt;
  end

  // Halt FSM: next state
  always_comb begin
    state_nxt = state;
    if (branch_taken)
      state_nxt = FS_RUN;
    else if (accept && is_halt_word)
      state_nxt = FS_HALT;
  end

  // Halt FSM: outputs
  always_comb begin
    halted = (state == FS_HALT);
  end

  // IF/ID register and accepted-fetch counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ifid_instr    <= NOP_WORD;
      ifid_pc_plus1 <= '0;
      ifid_valid    <= 1'b0;
      fetch_count   <= '0;
    end else if (branch_taken) begin
      ifid_instr    <= NOP_WORD;
      ifid_pc_plus1 <= '0;
      ifid_valid    <= 1'b0;
    end else if (stall) begin
      ifid_instr    <= ifid_instr;
    end else if (state == FS_HALT) begin
      ifid_instr    <= NOP_WORD;
      ifid_pc_plus1 <= '0;
      ifid_valid    <= 1'b0;
    end else begin
      ifid_instr    <= imem_data;
      ifid_pc_plus1 <= {{(32-PC_W){1'b0}}, pc_inc};
      ifid_valid    <= 1'b1;
      if (fetch_count != '1)
        fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

  logic        clk;
  logic        reset_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [10:0] pc;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus1;
  logic        ifid_valid;
  logic        halted;
  logic [31:0] fetch_count;

  logic [31:0] mem [0:2047];
  int unsigned n_pass;
  int unsigned n_chk;

  if_fetch_stage dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .pc            (pc),
    .ifid_instr    (ifid_instr),
    .ifid_pc_plus1 (ifid_pc_plus1),
    .ifid_valid    (ifid_valid),
    .halted        (halted),
    .fetch_count   (fetch_count)
  );

  assign imem_data = mem[imem_addr[10:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_pass = 0;
    n_chk  = 0;
    for (int i = 0; i < 2048; i++)
      mem[i] = 32'hA500_0000 | i;
    mem[15] = 32'hFFFF_FFFF;

    reset_n       = 1'b0;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'd0;
    #2;
    check("rst_pc",    {21'd0, pc}, 32'd0);
    check("rst_instr", ifid_instr, 32'h0);
    check("rst_pcp1",  ifid_pc_plus1, 32'd0);
    check("rst_valid", {31'd0, ifid_valid}, 32'd0);
    check("rst_halt",  {31'd0, halted}, 32'd0);
    check("rst_cnt",   fetch_count, 32'd0);
    reset_n = 1'b1;

    // Sequential run
    tick();
    check("e1_instr", ifid_instr, 32'hA500_0000);
    check("e1_pcp1",  ifid_pc_plus1, 32'd1);
    check("e1_pc",    {21'd0, pc}, 32'd1);
    check("e1_addr",  imem_addr, 32'd1);
    tick(); tick(); tick();
    check("e4_instr", ifid_instr, 32'hA500_0003);
    check("e4_pc",    {21'd0, pc}, 32'd4);
    check("e4_cnt",   fetch_count, 32'd4);

    // Stall two cycles at pc=4
    stall = 1'b1;
    tick(); tick();
    check("st_pc",    {21'd0, pc}, 32'd4);
    check("st_instr", ifid_instr, 32'hA500_0003);
    check("st_cnt",   fetch_count, 32'd4);
    stall = 1'b0;
    tick();
    check("rel_instr", ifid_instr, 32'hA500_0004);
    check("rel_pc",    {21'd0, pc}, 32'd5);
    check("rel_cnt",   fetch_count, 32'd5);

    // Mid-operation asynchronous reset, between edges
    check("pre_valid", {31'd0, ifid_valid}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_pc",    {21'd0, pc}, 32'd0);
    check("ar_instr", ifid_instr, 32'h0);
    check("ar_pcp1",  ifid_pc_plus1, 32'd0);
    check("ar_valid", {31'd0, ifid_valid}, 32'd0);
    check("ar_cnt",   fetch_count, 32'd0);
    reset_n = 1'b1;

    // Branch while stalled overrides the stall
    stall         = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 32'd8;
    tick();
    check("br_pc",    {21'd0, pc}, 32'd8);
    check("br_valid", {31'd0, ifid_valid}, 32'd0);
    check("br_instr", ifid_instr, 32'h0);
    check("br_cnt",   fetch_count, 32'd0);
    stall        = 1'b0;
    branch_taken = 1'b0;
    tick();
    check("br2_instr", ifid_instr, 32'hA500_0008);
    check("br2_pc",    {21'd0, pc}, 32'd9);
    check("br2_cnt",   fetch_count, 32'd1);

    // Run to HALT at mem[15]
    for (int i = 0; i < 6; i++) tick();
    check("ph_pc",  {21'd0, pc}, 32'd15);
    check("ph_cnt", fetch_count, 32'd7);
    tick();
    check("h_instr", ifid_instr, 32'hFFFF_FFFF);
    check("h_valid", {31'd0, ifid_valid}, 32'd1);
    check("h_halt",  {31'd0, halted}, 32'd1);
    check("h_pc",    {21'd0, pc}, 32'd15);
    check("h_pcp1",  ifid_pc_plus1, 32'd16);
    check("h_cnt",   fetch_count, 32'd8);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hb_valid", {31'd0, ifid_valid}, 32'd0);
      check("hb_pc",    {21'd0, pc}, 32'd15);
      check("hb_halt",  {31'd0, halted}, 32'd1);
    end
    check("hb_cnt", fetch_count, 32'd8);
    branch_taken  = 1'b1;
    branch_target = 32'd0;
    tick();
    check("hx_halt", {31'd0, halted}, 32'd0);
    check("hx_pc",   {21'd0, pc}, 32'd0);
    branch_taken = 1'b0;

    // Wrap-around from the last word; upper target bits ignored
    branch_taken  = 1'b1;
    branch_target = 32'hF000_07FF;
    tick();
    check("w_pc", {21'd0, pc}, 32'd2047);
    branch_taken = 1'b0;
    tick();
    check("w_instr", ifid_instr, 32'hA500_07FF);
    check("w_pcp1",  ifid_pc_plus1, 32'd0);
    check("w_pc0",   {21'd0, pc}, 32'd0);
    check("w_cnt",   fetch_count, 32'd9);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
